mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / debug) arbiter and sequencer for a single-port memory with fixed read latency.
// Define MEM_ARB_DBG_EN to enable the debug port; otherwise only the CPU is ever granted.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          cclk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant_dbg
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;   // 1: transaction belongs to the debug port
    logic          we_q, we_d;
    logic [AW-3:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic          grant;
    logic          pick_dbg;
    logic          unused_sig;

`ifdef MEM_ARB_DBG_EN
    logic rr_q, rr_d;   // 1: debug port wins the next tie

    always_comb begin
        grant    = cpu_req | dbg_req;
        pick_dbg = (cpu_req & dbg_req) ? rr_q : dbg_req;
        rr_d     = rr_q;
        if (state_q == IDLE && grant) begin
            rr_d = ~pick_dbg;
        end
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign unused_sig = ^{cpu_addr[1:0], dbg_addr[1:0]};
`else
    always_comb begin
        grant    = cpu_req;
        pick_dbg = 1'b0;
    end

    assign unused_sig = ^{cpu_addr[1:0], dbg_req, dbg_addr[1:0], dbg_rdata_q};
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d = pick_dbg;
                    we_d    = pick_dbg ? dbg_we : cpu_we;
                    addr_d  = pick_dbg ? dbg_addr[AW-1:2] : cpu_addr[AW-1:2];
                    wdata_d = pick_dbg ? dbg_wdata : cpu_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = ACK;
                end else begin
                    cnt_d   = 3'(MEM_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Count value 1 marks the cycle in which the memory data is valid.
                if (cnt_q == 3'd1) begin
                    if (owner_q) begin
                        dbg_rdata_d = mem_rdata;
                    end else begin
                        cpu_rdata_d = mem_rdata;
                    end
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Memory address/data come straight from the latch registers, so they hold after ISSUE.
    assign busy      = (state_q != IDLE);
    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = (state_q == ISSUE) & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = (state_q == ACK) & ~owner_q;

`ifdef MEM_ARB_DBG_EN
    assign dbg_rdata = dbg_rdata_q;
    assign dbg_ack   = (state_q == ACK) & owner_q;
    assign grant_dbg = busy & owner_q;
`else
    assign dbg_rdata = '0;
    assign dbg_ack   = 1'b0;
    assign grant_dbg = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT 1 and 3), each with a latency-exact memory model,
// checked against a word-level reference of memory contents and handshake timing.
module tb_mem_arbiter;
    localparam int N = 2;

    logic cclk = 1'b0;
    always #5 cclk = ~cclk;

    logic          rst;
    logic          mem_clr;
    logic [N-1:0]  cpu_req, cpu_we, dbg_req, dbg_we;
    logic [N-1:0]  cpu_ack, dbg_ack, mem_en, mem_we, busy, grant_dbg;
    logic [31:0]   cpu_addr [N];
    logic [31:0]   cpu_wdata [N];
    logic [31:0]   cpu_rdata [N];
    logic [31:0]   dbg_addr [N];
    logic [31:0]   dbg_wdata [N];
    logic [31:0]   dbg_rdata [N];
    logic [29:0]   mem_addr [N];
    logic [31:0]   mem_wdata [N];
    logic [31:0]   mem_rdata [N];

    int tests = 0;
    int fails = 0;

    logic [31:0] ref_mem [int];
    logic [31:0] exp_cpu_rd [N];
    logic [31:0] exp_dbg_rd [N];

    function automatic logic [31:0] fill(input logic [7:0] w);
        return {24'hC0DE00, w};
    endfunction

    function automatic int key(input bit i, input logic [7:0] w);
        return (i ? 256 : 0) + int'(w);
    endfunction

    function automatic logic [31:0] rd_ref(input bit i, input logic [7:0] w);
        int kk;
        kk = key(i, w);
        return ref_mem.exists(kk) ? ref_mem[kk] : fill(w);
    endfunction

    for (genvar gi = 0; gi < N; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 1 : 3;
        logic [31:0]  mem [256];
        logic [255:0] written;
        logic [31:0]  pipe [4];
        logic [7:0]   wa;

        assign wa = mem_addr[gi][7:0];

        mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
            .cclk      (cclk),
            .rst       (rst),
            .cpu_req   (cpu_req[gi]),
            .cpu_we    (cpu_we[gi]),
            .cpu_addr  (cpu_addr[gi]),
            .cpu_wdata (cpu_wdata[gi]),
            .cpu_rdata (cpu_rdata[gi]),
            .cpu_ack   (cpu_ack[gi]),
            .dbg_req   (dbg_req[gi]),
            .dbg_we    (dbg_we[gi]),
            .dbg_addr  (dbg_addr[gi]),
            .dbg_wdata (dbg_wdata[gi]),
            .dbg_rdata (dbg_rdata[gi]),
            .dbg_ack   (dbg_ack[gi]),
            .mem_en    (mem_en[gi]),
            .mem_we    (mem_we[gi]),
            .mem_addr  (mem_addr[gi]),
            .mem_wdata (mem_wdata[gi]),
            .mem_rdata (mem_rdata[gi]),
            .busy      (busy[gi]),
            .grant_dbg (grant_dbg[gi])
        );

        // Read data is valid exactly LAT cycles after the mem_en cycle; junk otherwise.
        always @(posedge cclk) begin
            if (mem_clr) begin
                written <= '0;
            end else if (mem_en[gi] && mem_we[gi]) begin
                mem[wa]     <= mem_wdata[gi];
                written[wa] <= 1'b1;
            end
            pipe[0] <= (mem_en[gi] && !mem_we[gi]) ? (written[wa] ? mem[wa] : fill(wa))
                                                   : {16'hBAD0, 16'($urandom)};
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata[gi] = pipe[LAT-1];
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit i, input bit p, input logic v);
        if (p) dbg_req[i] = v;
        else   cpu_req[i] = v;
    endtask

    // One complete transaction on port p (0 CPU, 1 debug) of instance i; optionally drops req in cycle 2.
    task automatic txn(input bit i, input bit p, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input bit drop);
        int          exp_ack;
        logic [7:0]  w;
        logic        own_ack, oth_ack;
        w       = addr[9:2];
        exp_ack = we ? 2 : 2 + ((i == 1'b0) ? 1 : 3);
        if (!we) begin
            if (p) exp_dbg_rd[i] = rd_ref(i, w);
            else   exp_cpu_rd[i] = rd_ref(i, w);
        end
        @(negedge cclk);
        if (p) begin
            dbg_we[i] = we; dbg_addr[i] = addr; dbg_wdata[i] = wd;
        end else begin
            cpu_we[i] = we; cpu_addr[i] = addr; cpu_wdata[i] = wd;
        end
        set_req(i, p, 1'b1);
        for (int k = 1; k <= exp_ack + 1; k++) begin
            @(negedge cclk);
            own_ack = p ? dbg_ack[i] : cpu_ack[i];
            oth_ack = p ? cpu_ack[i] : dbg_ack[i];
            chk1("mem_en", mem_en[i], k == 1);
            if (k == 1) begin
                chk1("mem_we", mem_we[i], we);
                chk32("mem_addr", {2'b00, mem_addr[i]}, {2'b00, addr[31:2]});
                if (we) chk32("mem_wdata", mem_wdata[i], wd);
            end else begin
                chk1("mem_we_idle", mem_we[i], 1'b0);
            end
            chk1("busy", busy[i], k <= exp_ack);
            chk1("grant_dbg", grant_dbg[i], p && (k <= exp_ack));
            chk1("own_ack", own_ack, k == exp_ack);
            chk1("other_ack", oth_ack, 1'b0);
            if (k == exp_ack) begin
                chk32("cpu_rdata", cpu_rdata[i], exp_cpu_rd[i]);
                chk32("dbg_rdata", dbg_rdata[i], exp_dbg_rd[i]);
            end
            if (k == exp_ack || (drop && k == 2)) set_req(i, p, 1'b0);
        end
        set_req(i, p, 1'b0);
        if (we) ref_mem[key(i, w)] = wd;
        $display("[TB] inst%0d %s %s addr=%h data=%h ack_cycle=%0d", i, p ? "DBG" : "CPU",
                 we ? "WR" : "RD", addr, we ? wd : (p ? exp_dbg_rd[i] : exp_cpu_rd[i]), exp_ack);
    endtask

`ifdef MEM_ARB_DBG_EN
    // Both ports hold req continuously: grants must alternate CPU, DBG, CPU, DBG from reset.
    task automatic arb_test(input bit i);
        logic [31:0] da, db;
        bit          ow;
        da = $urandom;
        db = $urandom;
        @(negedge cclk);
        cpu_we[i] = 1'b1; cpu_addr[i] = 32'h0C0; cpu_wdata[i] = da;
        dbg_we[i] = 1'b1; dbg_addr[i] = 32'h0C4; dbg_wdata[i] = db;
        cpu_req[i] = 1'b1;
        dbg_req[i] = 1'b1;
        for (int g = 0; g < 4; g++) begin
            ow = ((g % 2) == 1);
            for (int k = 1; k <= 3; k++) begin
                @(negedge cclk);
                chk1("arb_mem_en", mem_en[i], k == 1);
                if (k == 1) chk32("arb_mem_addr", {2'b00, mem_addr[i]}, ow ? 32'h31 : 32'h30);
                chk1("arb_grant_dbg", grant_dbg[i], ow && k <= 2);
                chk1("arb_cpu_ack", cpu_ack[i], !ow && k == 2);
                chk1("arb_dbg_ack", dbg_ack[i], ow && k == 2);
                chk1("arb_busy", busy[i], k <= 2);
                if (g == 3 && k == 2) begin
                    cpu_req[i] = 1'b0;
                    dbg_req[i] = 1'b0;
                end
            end
            $display("[TB] inst%0d arbitration grant %0d -> %s", i, g, ow ? "DBG" : "CPU");
        end
        ref_mem[key(i, 8'h30)] = da;
        ref_mem[key(i, 8'h31)] = db;
    endtask
`endif

    task automatic check_zero(input bit i, input string tag);
        chk1({tag, "_busy"}, busy[i], 1'b0);
        chk1({tag, "_mem_en"}, mem_en[i], 1'b0);
        chk1({tag, "_mem_we"}, mem_we[i], 1'b0);
        chk1({tag, "_cpu_ack"}, cpu_ack[i], 1'b0);
        chk1({tag, "_dbg_ack"}, dbg_ack[i], 1'b0);
        chk1({tag, "_grant_dbg"}, grant_dbg[i], 1'b0);
        chk32({tag, "_cpu_rdata"}, cpu_rdata[i], 32'h0);
        chk32({tag, "_dbg_rdata"}, dbg_rdata[i], 32'h0);
        chk32({tag, "_mem_addr"}, {2'b00, mem_addr[i]}, 32'h0);
        chk32({tag, "_mem_wdata"}, mem_wdata[i], 32'h0);
    endtask

    initial begin
        bit          ri, rp, rwe, rdrop;
        logic [31:0] raddr;

        rst     = 1'b1;
        mem_clr = 1'b1;
        cpu_req = '0; cpu_we = '0; dbg_req = '0; dbg_we = '0;
        for (int j = 0; j < N; j++) begin
            cpu_addr[j] = '0; cpu_wdata[j] = '0; dbg_addr[j] = '0; dbg_wdata[j] = '0;
            exp_cpu_rd[j] = '0; exp_dbg_rd[j] = '0;
        end
        repeat (3) @(negedge cclk);
        for (int j = 0; j < N; j++) check_zero(bit'(j), "reset");
        rst     = 1'b0;
        mem_clr = 1'b0;

`ifdef MEM_ARB_DBG_EN
        for (int j = 0; j < N; j++) arb_test(bit'(j));
`else
        dbg_req = '1;
        dbg_we  = '0;
`endif

        for (int j = 0; j < N; j++) begin
            txn(bit'(j), 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0);
            txn(bit'(j), 1'b0, 1'b1, 32'h080, 32'h12345678, 1'b0);
            txn(bit'(j), 1'b0, 1'b0, 32'h080, 32'h0, 1'b0);
            txn(bit'(j), 1'b0, 1'b0, 32'h103, 32'h0, 1'b0);
        end

`ifdef MEM_ARB_DBG_EN
        txn(1'b1, 1'b0, 1'b1, 32'h200, 32'hAAAA0000, 1'b0);
        txn(1'b1, 1'b0, 1'b1, 32'h204, 32'h5555FFFF, 1'b0);
        txn(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0);
        txn(1'b1, 1'b0, 1'b0, 32'h204, 32'h0, 1'b1);
        txn(1'b1, 1'b1, 1'b1, 32'h208, 32'h0BADF00D, 1'b0);
`endif

        for (int r = 0; r < 40; r++) begin
            ri    = 1'($urandom_range(0, 1));
            rwe   = 1'($urandom_range(0, 1));
            rdrop = 1'($urandom_range(0, 1));
            raddr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
`ifdef MEM_ARB_DBG_EN
            rp = 1'($urandom_range(0, 1));
`else
            rp = 1'b0;
            dbg_req[ri]   = 1'($urandom_range(0, 1));
            dbg_we[ri]    = 1'($urandom_range(0, 1));
            dbg_addr[ri]  = $urandom;
            dbg_wdata[ri] = $urandom;
`endif
            txn(ri, rp, rwe, raddr, $urandom, rdrop);
        end

        // Reset while instance 1 (MEM_LAT 3) is waiting on read data.
        @(negedge cclk);
        cpu_we[1] = 1'b0; cpu_addr[1] = 32'h44; cpu_req[1] = 1'b1;
        @(negedge cclk);
        @(negedge cclk);
        chk1("pre_reset_busy", busy[1], 1'b1);
        rst = 1'b1;
        cpu_req[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge cclk);
            check_zero(1'b1, "midrst");
        end
        rst = 1'b0;
        for (int j = 0; j < N; j++) begin
            exp_cpu_rd[j] = '0;
            exp_dbg_rd[j] = '0;
        end
        @(negedge cclk);
        chk1("post_reset_cpu_ack", cpu_ack[1], 1'b0);
        chk1("post_reset_busy", busy[1], 1'b0);
        $display("[TB] inst1 reset during WAIT, no ack");
        for (int j = 0; j < N; j++) txn(bit'(j), 1'b0, 1'b0, 32'h40, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
